// File: rtl/display_test_pattern.sv
// rtl/display_test_pattern.sv - VGA 640x480@60 colour-bar test pattern; DISPLAY_TEST_SCROLL_EN enables bar scrolling
module display_test_pattern #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hs,
    output logic       vs,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_MAX = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_RIGHT  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_BOTTOM = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          pix_en;
    logic [CW-1:0] x;
    logic [2:0]    bar;
    logic          active;
    logic          border;
    logic          hs_next;
    logic          vs_next;
    logic [11:0]   rgb_next;

    assign pix_en = (div_cnt == DIV_LAST);

`ifdef DISPLAY_TEST_SCROLL_EN
    logic [CW-1:0] offset;
    logic [CW:0]   x_sum;

    // Advance the scroll offset once per frame, on the last pixel of the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            offset <= '0;
        end else if (pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
            offset <= (offset == H_RIGHT) ? '0 : offset + 1'b1;
        end
    end

    // Bar coordinate is the line position shifted by the offset, folded back into the visible width
    always_comb begin
        x_sum = {1'b0, h_cnt} + {1'b0, offset};
        x     = (x_sum >= {1'b0, H_ACT}) ? CW'(x_sum - {1'b0, H_ACT}) : x_sum[CW-1:0];
    end
`else
    // Static pattern: bar coordinate is the line position itself
    always_comb begin
        x = h_cnt;
    end
`endif

    // Decode sync and colour for the pixel the counters currently point at
    always_comb begin
        hs_next  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_next  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        border   = (h_cnt == '0) || (h_cnt == H_RIGHT) || (v_cnt == '0) || (v_cnt == V_BOTTOM);
        bar      = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= CW'(i * (H_ACTIVE / 8))) begin
                bar = 3'(i);
            end
        end
        rgb_next = 12'h000;
        if (active) begin
            if (border) begin
                rgb_next = 12'hF00;
            end else begin
                case (bar)
                    3'd0:    rgb_next = 12'hFFF;
                    3'd1:    rgb_next = 12'hFF0;
                    3'd2:    rgb_next = 12'h0FF;
                    3'd3:    rgb_next = 12'h0F0;
                    3'd4:    rgb_next = 12'hF0F;
                    3'd5:    rgb_next = 12'hF00;
                    3'd6:    rgb_next = 12'h00F;
                    default: rgb_next = 12'h000;
                endcase
            end
        end
    end

    // Pixel-rate divider, raster counters and registered outputs, all updated on pix_en
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            hs        <= 1'b1;
            vs        <= 1'b1;
            {r, g, b} <= 12'h000;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
            if (pix_en) begin
                hs        <= hs_next;
                vs        <= vs_next;
                {r, g, b} <= rgb_next;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_test_pattern.sv
// tb/tb_display_test_pattern.sv - randomized self-checking bench for display_test_pattern
module tb_display_test_pattern;

    localparam int CD  = 4;
    localparam int HA  = 160;
    localparam int HF  = 8;
    localparam int HSY = 16;
    localparam int HB  = 16;
    localparam int VA  = 12;
    localparam int VF  = 2;
    localparam int VSY = 2;
    localparam int VB  = 3;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;

    int checks = 0;
    int errors = 0;
    int c      = 0;

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    display_test_pattern #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hs(hs),
        .vs(vs),
        .r(r),
        .g(g),
        .b(b)
    );

    always #5 clk = ~clk;

    // Expected {hs, vs, rgb} after cnt clock edges since reset was released.
    // Pixel p is shown once its pix_en edge has passed: edge CD*(p+1).
    function automatic logic [13:0] model(input int cnt);
        int p, h, v, frame, x;
        logic hs_e, vs_e;
        logic [11:0] rgb;
        if (cnt < CD) return {1'b1, 1'b1, 12'h000};
        p     = cnt / CD - 1;
        h     = p % HT;
        v     = (p / HT) % VT;
        frame = p / (HT * VT);
        hs_e  = !((h >= HA + HF) && (h < HA + HF + HSY));
        vs_e  = !((v >= VA + VF) && (v < VA + VF + VSY));
        rgb   = 12'h000;
        if (h < HA && v < VA) begin
            if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
                rgb = 12'hF00;
            end else begin
`ifdef DISPLAY_TEST_SCROLL_EN
                x = (h + (frame % HA)) % HA;
`else
                x = h + 0 * frame;
`endif
                rgb = bars[x / (HA / 8)];
            end
        end
        return {hs_e, vs_e, rgb};
    endfunction

    // One clock: track edges since release, then settle at the falling edge
    task automatic advance();
        @(posedge clk);
        if (rst) c = 0;
        else c++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        n = 3 + $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            advance();
            checks++;
            if ({hs, vs, r, g, b} !== {1'b1, 1'b1, 12'h000}) begin
                errors++;
                if (errors <= 20) $display("FAIL reset_hold clk=%0d got=%h want=%h", i, {hs, vs, r, g, b}, {1'b1, 1'b1, 12'h000});
            end
        end
    endtask

    task automatic test_first_pixels();
        logic [13:0] exp;
        rst = 1'b0;
        for (int i = 0; i < 3 * CD; i++) begin
            advance();
            exp = model(c);
            checks++;
            if ({hs, vs, r, g, b} !== exp) begin
                errors++;
                if (errors <= 20) $display("FAIL first_pixels edge=%0d got=%h want=%h", c, {hs, vs, r, g, b}, exp);
            end
        end
    endtask

    task automatic test_stream();
        logic [13:0] exp;
        int hs_run = 0, vs_run = 0, last_vs_fall = -1;
        logic hs_prev = 1'b1, vs_prev = 1'b1;
        int total = (HT * VT * CD * 23) / 10;
        for (int i = 0; i < total; i++) begin
            advance();
            exp = model(c);
            checks++;
            if ({hs, vs, r, g, b} !== exp) begin
                errors++;
                if (errors <= 20) $display("FAIL stream edge=%0d got=%h want=%h", c, {hs, vs, r, g, b}, exp);
            end
            if (!hs) hs_run++;
            if (hs && !hs_prev) begin
                checks++;
                if (hs_run !== HSY * CD) begin
                    errors++;
                    if (errors <= 20) $display("FAIL hs_width got=%0d want=%0d", hs_run, HSY * CD);
                end
                hs_run = 0;
            end
            if (!vs) vs_run++;
            if (vs && !vs_prev) begin
                checks++;
                if (vs_run !== VSY * HT * CD) begin
                    errors++;
                    if (errors <= 20) $display("FAIL vs_width got=%0d want=%0d", vs_run, VSY * HT * CD);
                end
                vs_run = 0;
            end
            if (!vs && vs_prev) begin
                if (last_vs_fall >= 0) begin
                    checks++;
                    if (c - last_vs_fall !== HT * VT * CD) begin
                        errors++;
                        if (errors <= 20) $display("FAIL frame_period got=%0d want=%0d", c - last_vs_fall, HT * VT * CD);
                    end
                end
                last_vs_fall = c;
            end
            hs_prev = hs;
            vs_prev = vs;
        end
    endtask

    task automatic test_mid_reset();
        logic [13:0] exp;
        int wait_n, hold_n;
        for (int it = 0; it < 4; it++) begin
            wait_n = $urandom_range(1, HT * CD * 3);
            hold_n = (it == 0) ? 1 : $urandom_range(1, 3);
            for (int i = 0; i < wait_n; i++) begin
                advance();
                exp = model(c);
                checks++;
                if ({hs, vs, r, g, b} !== exp) begin
                    errors++;
                    if (errors <= 20) $display("FAIL mid_pre edge=%0d got=%h want=%h", c, {hs, vs, r, g, b}, exp);
                end
            end
            rst = 1'b1;
            for (int i = 0; i < hold_n; i++) begin
                advance();
                checks++;
                if ({hs, vs, r, g, b} !== {1'b1, 1'b1, 12'h000}) begin
                    errors++;
                    if (errors <= 20) $display("FAIL mid_reset got=%h want=%h", {hs, vs, r, g, b}, {1'b1, 1'b1, 12'h000});
                end
            end
            rst = 1'b0;
            for (int i = 0; i < 2 * HT * CD; i++) begin
                advance();
                exp = model(c);
                checks++;
                if ({hs, vs, r, g, b} !== exp) begin
                    errors++;
                    if (errors <= 20) $display("FAIL mid_post edge=%0d got=%h want=%h", c, {hs, vs, r, g, b}, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_pixels();
        test_stream();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
